burst_mem_responder: RTL and testbench
======================================

Name: burst_mem_responder

Overview:
- Memory-side responder for the 64-bit burst interface that the cacheline adaptor drives.
- Accepts one line read or line write per request and stores 256-bit lines in an internal array.
- After a programmable latency, answers with a 4-beat burst, asserting resp once per beat.
- Serves as the synthesizable backing memory for top-level simulation and is the reference model for adaptor verification.

Parameters:
- LINES, 256, number of 256-bit lines stored; must be a power of 2.
- LATENCY, 4, cycles from the request-accept cycle to the first resp cycle; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bmem_address  input  32  byte address of the line; bits [4:0] are expected to be 0.
- bmem_read  input  1  line read request; held by the initiator until the last resp.
- bmem_write  input  1  line write request; held by the initiator until the last resp.
- bmem_wdata  input  64  write beat k, presented by the initiator while resp is high for beat k.
- bmem_rdata  output  64  read beat k, valid while resp is high.
- bmem_resp  output  1  beat valid/accepted strobe.
- bmem_error  output  1  sticky protocol-error flag.

Behaviour:
- Reset: bmem_resp=0, bmem_rdata=0, bmem_error=0, state IDLE, counters 0. Array contents are not reset.
- Line index: bmem_address[5 +: log2(LINES)]. Higher address bits are ignored, so addresses alias modulo LINES*32 bytes.
- Beat k (k=0..3) covers line bits [64k+63:64k], lowest beat first.
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE:
  - Read xor write high: latch index and op, clear the latency counter.
  - Go to WAIT, or to BURST if LATENCY=1.
  - Read and write both high: nothing is accepted, bmem_error is set, stay in IDLE.
  - Any of bmem_address[4:0] nonzero on an accepted request: the request proceeds using the line index and bmem_error is set.
- WAIT: the counter increments each cycle; enter BURST so that the first resp appears exactly LATENCY cycles after the accept cycle.
  - Example: LATENCY=4, request first high in cycle t, first resp in cycle t+4.
- BURST: bmem_resp=1 for exactly 4 consecutive cycles, beat counter 0..3.
  - Read: bmem_rdata = array[index] beat k during the cycle of beat k. It is driven from registers, so there is no combinational path from inputs.
  - Write: at the rising edge ending the beat-k resp cycle, bmem_wdata is written into beat k of array[index]. The line is fully updated after beat 3.
  - After beat 3, go to DONE.
- DONE: one cycle with resp=0, then IDLE. The initiator must drop read/write in the cycle after the last resp. A request still high in IDLE is treated as a new request.
- Outside BURST: bmem_resp=0 and bmem_rdata=0.
- Input changes to read/write/address after accept are ignored until IDLE.
- A read to the same line immediately after a write returns the new data (no bypass is needed, since the write completes before DONE).
- bmem_error stays set until reset and does not alter timing of legal requests.
- Reset asserted mid-WAIT or mid-BURST: immediately IDLE, resp=0, rdata=0.
  - A partially written line keeps the beats already written; the remaining beats are unchanged.
- Throughput: one line per LATENCY+5 cycles (request accept to next accept).

Test Plan:
- Write 0x1000 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read 0x1000 -> 4 resp cycles returning the same beats in order; bmem_error=0.
- LATENCY=4, read asserted at cycle 10 -> resp high exactly cycles 14–17, low at 18; next request accepted at 19.
- Write 0x0000, then read 0x0000 + LINES*32 -> the aliased line returns the written data.
- bmem_read=bmem_write=1 at 0x40 -> no resp ever, bmem_error=1 held until reset_n low.
- Read 0x1004 -> data of line 0x1000 returned, bmem_error=1.
- Write 0x2000 (old data all 0xAA), reset_n pulsed low during beat 2:
  - resp drops asynchronously.
  - A subsequent read of 0x2000 returns beats 0–1 new and beats 2–3 of 0xAA.

Source files
------------

// File: rtl/burst_mem_responder.sv
// burst_mem_responder
//
// Memory-side responder for a 64-bit, 4-beat line burst interface. It stores
// LINES lines of 256 bits and answers each accepted line read or write with
// exactly four consecutive resp beats. The first beat comes LATENCY cycles
// after the accept cycle. A line is transferred lowest 64-bit beat first.
//
// Parameters:
//   LINES    number of 256-bit lines; must be a power of 2 and >= 2
//   LATENCY  cycles from the accept cycle to the first resp cycle; >= 1
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   bmem_address  byte address of the line (bits [4:0] expected zero)
//   bmem_read     line read request, held until the last resp
//   bmem_write    line write request, held until the last resp
//   bmem_wdata    write beat k, presented while resp is high for beat k
//   bmem_rdata    read beat k, valid while resp is high (registered)
//   bmem_resp     beat valid / accepted strobe
//   bmem_error    sticky protocol-error flag, cleared only by reset
module burst_mem_responder #(
    parameter int LINES   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] bmem_address,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic [63:0] bmem_rdata,
    output logic        bmem_resp,
    output logic        bmem_error
);

    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    // WAIT is left when the counter reaches this value. The counter is 0 in
    // the first WAIT cycle, so LATENCY-1 WAIT cycles separate accept and beat 0.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               op_write_q, op_write_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [1:0]         beat_q, beat_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               error_q, error_d;

    logic [63:0]        mem [LINES][4];

    logic [IDX_W-1:0]   addr_index;
    logic [IDX_W-1:0]   rd_line;
    logic [1:0]         rd_beat;
    logic               load_rdata;

    // Address bits above the line index only cause aliasing and are ignored.
    logic               unused_addr_hi;

    assign addr_index     = bmem_address[5 +: IDX_W];
    assign unused_addr_hi = ^bmem_address[31:5+IDX_W];

    // Next-state and datapath control. Read data is fetched one cycle ahead
    // into rdata_q so that bmem_rdata is a plain register output.
    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        index_d    = index_q;
        lat_cnt_d  = lat_cnt_q;
        beat_d     = beat_q;
        error_d    = error_q;
        rdata_d    = '0;
        rd_line    = index_q;
        rd_beat    = '0;
        load_rdata = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bmem_read && bmem_write) begin
                    error_d = 1'b1;
                end else if (bmem_read || bmem_write) begin
                    op_write_d = bmem_write;
                    index_d    = addr_index;
                    lat_cnt_d  = '0;
                    beat_d     = '0;
                    if (bmem_address[4:0] != 5'd0) begin
                        error_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        // Beat 0 is next cycle, so fetch from the live address.
                        state_d    = ST_BURST;
                        rd_line    = addr_index;
                        load_rdata = !bmem_write;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q + CNT_W'(1);
                if (lat_cnt_q == WAIT_LAST) begin
                    state_d    = ST_BURST;
                    beat_d     = '0;
                    load_rdata = !op_write_q;
                end
            end

            ST_BURST: begin
                if (beat_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    beat_d     = beat_q + 2'd1;
                    rd_beat    = beat_q + 2'd1;
                    load_rdata = !op_write_q;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_rdata) begin
            rdata_d = mem[rd_line][rd_beat];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_write_q <= 1'b0;
            index_q    <= '0;
            lat_cnt_q  <= '0;
            beat_q     <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            index_q    <= index_d;
            lat_cnt_q  <= lat_cnt_d;
            beat_q     <= beat_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    // Line storage is not reset. A reset during a write burst stops further
    // beat writes because state_q leaves BURST immediately.
    always_ff @(posedge clk) begin
        if (state_q == ST_BURST && op_write_q) begin
            mem[index_q][beat_q] <= bmem_wdata;
        end
    end

    assign bmem_resp  = (state_q == ST_BURST);
    assign bmem_rdata = rdata_q;
    assign bmem_error = error_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder
//
// Drives line reads and writes into burst_mem_responder and compares every
// burst against a line-array model indexed by (address / 32) mod LINES.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_burst_mem_responder;

    localparam int LINES   = 256;
    localparam int LATENCY = 4;
    localparam int PERIOD  = L_PERIOD();

    function automatic int L_PERIOD();
        return LATENCY + 5;
    endfunction

    logic        clk;
    logic        reset_n;
    logic [31:0] bmem_address;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic [63:0] bmem_rdata;
    logic        bmem_resp;
    logic        bmem_error;

    int passCount;
    int checkCount;

    logic [255:0] modelMem   [LINES];
    bit           modelValid [LINES];

    burst_mem_responder #(
        .LINES   (LINES),
        .LATENCY (LATENCY)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bmem_address (bmem_address),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp),
        .bmem_error   (bmem_error)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a bounded wait is ever missed.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int lineOf(input logic [31:0] addr);
        return int'((addr / 32) % LINES);
    endfunction

    function automatic logic [255:0] randomLine();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[32*i +: 32] = $urandom;
        end
        return l;
    endfunction

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Holds reset for two cycles and checks the reset values.
    task automatic resetDut();
        reset_n = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetResp", bmem_resp, 1'b0);
        checkOutput("resetRdata", bmem_rdata, 64'd0);
        checkOutput("resetError", bmem_error, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete line transaction as a well-behaved initiator: request,
    // wait for the first resp, move four beats, drop the request in DONE.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                                 input logic [255:0] wline, output logic [255:0] rline);
        int cyc;
        rline = '0;
        @(negedge clk);
        bmem_address = addr;
        bmem_read    = !isWrite;
        bmem_write   = isWrite;
        bmem_wdata   = '0;
        @(negedge clk);
        cyc = 1;
        // The request has been accepted; later address changes must not matter.
        bmem_address = $urandom;
        while (!bmem_resp && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (!bmem_resp) begin
            checkOutput("respTimeout", 1'b0, 1'b1);
            bmem_read  = 1'b0;
            bmem_write = 1'b0;
            return;
        end
        checkOutput("firstRespLatency", cyc, LATENCY);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("respBeat", bmem_resp, 1'b1);
            rline[64*k +: 64] = bmem_rdata;
            bmem_wdata = wline[64*k +: 64];
        end
        @(negedge clk);
        checkOutput("respAfterBurst", bmem_resp, 1'b0);
        checkOutput("rdataAfterBurst", bmem_rdata, 64'd0);
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [255:0] line);
        logic [255:0] dummy;
        applyStimulus(1'b1, addr, line, dummy);
        modelMem[lineOf(addr)]   = line;
        modelValid[lineOf(addr)] = 1'b1;
    endtask

    task automatic doRead(input string tag, input logic [31:0] addr,
                          output logic [255:0] rline);
        applyStimulus(1'b0, addr, '0, rline);
        checkOutput(tag, rline, modelMem[lineOf(addr)]);
    endtask

    initial begin
        logic [255:0] rline;
        logic [255:0] known;
        logic [255:0] newLine;
        logic [255:0] expectLine;
        logic [31:0]  addr;
        bit           sawResp;
        int           cyc;

        passCount    = 0;
        checkCount   = 0;
        reset_n      = 1'b0;
        bmem_address = '0;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_wdata   = '0;

        $display("[TB] reset");
        resetDut();

        $display("[TB] write then read back 0x1000");
        known = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        doWrite(32'h1000, known);
        doRead("readBack1000", 32'h1000, rline);
        checkOutput("readBack1000Const", rline, known);
        checkOutput("errorAfterLegal", bmem_error, 1'b0);

        $display("[TB] back-to-back timing with read held");
        @(negedge clk);
        bmem_address = 32'h1000;
        bmem_read    = 1'b1;
        for (int c = 0; c < 2 * PERIOD; c++) begin
            checkOutput("respPattern", bmem_resp,
                        ((c % PERIOD) >= LATENCY) && ((c % PERIOD) < LATENCY + 4));
            @(negedge clk);
        end
        bmem_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("respIdleAfterHeld", bmem_resp, 1'b0);

        $display("[TB] aliasing");
        newLine = randomLine();
        doWrite(32'h0000, newLine);
        doRead("aliasRead", 32'(LINES * 32), rline);
        checkOutput("aliasReadConst", rline, newLine);

        $display("[TB] read and write together");
        @(negedge clk);
        bmem_address = 32'h40;
        bmem_read    = 1'b1;
        bmem_write   = 1'b1;
        sawResp      = 1'b0;
        repeat (20) begin
            @(negedge clk);
            sawResp |= bmem_resp;
        end
        checkOutput("bothHighNoResp", sawResp, 1'b0);
        checkOutput("bothHighError", bmem_error, 1'b1);
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("errorSticky", bmem_error, 1'b1);
        resetDut();

        $display("[TB] misaligned read");
        doRead("misalignedRead", 32'h1004, rline);
        checkOutput("misalignedReadConst", rline, known);
        checkOutput("misalignedError", bmem_error, 1'b1);
        resetDut();

        $display("[TB] reset during write burst");
        doWrite(32'h2000, {4{64'hAAAA_AAAA_AAAA_AAAA}});
        newLine = randomLine();
        @(negedge clk);
        bmem_address = 32'h2000;
        bmem_write   = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bmem_resp && cyc < 60);
        checkOutput("rstBurstLatency", cyc, LATENCY);
        bmem_wdata = newLine[63:0];
        @(negedge clk);
        bmem_wdata = newLine[127:64];
        @(negedge clk);
        checkOutput("rstBurstBeat2Resp", bmem_resp, 1'b1);
        bmem_wdata = newLine[191:128];
        reset_n = 1'b0;
        #1;
        checkOutput("rstAsyncResp", bmem_resp, 1'b0);
        checkOutput("rstAsyncRdata", bmem_rdata, 64'd0);
        bmem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        expectLine = {64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, newLine[127:0]};
        modelMem[lineOf(32'h2000)][127:0] = newLine[127:0];
        doRead("partialWrite", 32'h2000, rline);
        checkOutput("partialWriteConst", rline, expectLine);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 24; i++) begin
            addr = 32'($urandom_range(0, 3) * LINES * 32 + ($urandom_range(0, 7) * 16 + 3) * 32);
            if (!modelValid[lineOf(addr)] || ($urandom_range(0, 1) == 1)) begin
                doWrite(addr, randomLine());
            end else begin
                doRead("randomRead", addr, rline);
            end
        end
        checkOutput("errorAfterRandom", bmem_error, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
